// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : drains a first-word-fall-through FIFO and serialises each word LSB
// first with 16x oversampled timing; even parity bit via UART_TX_PARITY_EN.
// Rev 1.0
// ============================================================================
module uart_tx #(
    parameter int Data_bits  = 8,
    parameter int Dvsr_width = 11,
    parameter int Stop_ticks = 16
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [Dvsr_width-1:0] dvsr,
    input  logic                  fifo_empty,
    input  logic [Data_bits-1:0]  fifo_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick
);
    localparam int TICK_MAX = (Stop_ticks > 16) ? Stop_ticks : 16;
    localparam int SW       = $clog2(TICK_MAX);
    localparam int NW       = (Data_bits > 1) ? $clog2(Data_bits) : 1;

    localparam logic [SW-1:0] BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] STOP_LAST = SW'(Stop_ticks - 1);
    localparam logic [NW-1:0] DATA_LAST = NW'(Data_bits - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                state, state_n;
    logic [Dvsr_width-1:0] div_cnt, div_n;
    logic [Dvsr_width-1:0] dvsr_q, dvsr_n;
    logic [SW-1:0]         s_cnt, s_n;
    logic [NW-1:0]         n_cnt, n_n;
    logic [Data_bits-1:0]  shreg, sh_n;
    logic                  tx_q, tx_n;
    logic                  tick;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_n;
`endif

    // Divisor is latched per frame so a mid-frame change cannot disturb bit timing.
    assign tick    = (state != S_IDLE) && (div_cnt == dvsr_q);
    assign tx      = tx_q;
    assign tx_busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            dvsr_q  <= '0;
            s_cnt   <= '0;
            n_cnt   <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            dvsr_q  <= dvsr_n;
            s_cnt   <= s_n;
            n_cnt   <= n_n;
            shreg   <= sh_n;
            tx_q    <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        div_n        = '0;
        dvsr_n       = dvsr_q;
        s_n          = s_cnt;
        n_n          = n_cnt;
        sh_n         = shreg;
        tx_n         = tx_q;
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n        = par_q;
`endif
        if (state != S_IDLE) begin
            div_n = tick ? '0 : div_cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                s_n  = '0;
                n_n  = '0;
                // Reset gating keeps the pop strobe quiet while the block is held in reset.
                if (!fifo_empty && Reset) begin
                    fifo_rd = 1'b1;
                    sh_n    = fifo_data;
                    dvsr_n  = dvsr;
                    tx_n    = 1'b0;
                    state_n = S_START;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^fifo_data;
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    if (s_cnt == BIT_LAST) begin
                        s_n     = '0;
                        tx_n    = shreg[0];
                        state_n = S_DATA;
                    end else begin
                        s_n = s_cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (s_cnt == BIT_LAST) begin
                        s_n  = '0;
                        sh_n = shreg >> 1;
                        if (n_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx_n    = par_q;
                            state_n = S_PARITY;
`else
                            tx_n    = 1'b1;
                            state_n = S_STOP;
`endif
                        end else begin
                            n_n  = n_cnt + 1'b1;
                            tx_n = sh_n[0];
                        end
                    end else begin
                        s_n = s_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (s_cnt == BIT_LAST) begin
                        s_n     = '0;
                        tx_n    = 1'b1;
                        state_n = S_STOP;
                    end else begin
                        s_n = s_cnt + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                tx_n = 1'b1;
                if (tick) begin
                    if (s_cnt == STOP_LAST) begin
                        s_n          = '0;
                        tx_done_tick = 1'b1;
                        state_n      = S_IDLE;
                    end else begin
                        s_n = s_cnt + 1'b1;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = S_IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// tb_uart_tx : FIFO model feeds the transmitter; expected words are queued on push
// and compared cycle by cycle against the serial waveform.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        int   n;
        int   bad;
        int   bad_k;
        logic bad_got;
        logic bad_want;
        int   done_at;
        int   done_cnt;
        int   side_bad;
    } frame_t;

    logic        clk   = 1'b0;
    logic        Reset = 1'b1;
    logic [10:0] dvsr  = '0;
    logic [7:0]  mem [16];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd, tx, tx_busy, tx_done_tick;
    logic        empty2 = 1'b1;
    logic [7:0]  data2  = 8'h00;
    logic        rd2, tx2, busy2, done2;
    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr % 16];

    uart_tx #(.Data_bits(8), .Dvsr_width(11), .Stop_ticks(16)) u_dut (
        .clk(clk), .Reset(Reset), .dvsr(dvsr), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick)
    );

    uart_tx #(.Data_bits(8), .Dvsr_width(11), .Stop_ticks(32)) u_dut2 (
        .clk(clk), .Reset(Reset), .dvsr(dvsr), .fifo_empty(empty2),
        .fifo_data(data2), .fifo_rd(rd2), .tx(tx2), .tx_busy(busy2),
        .tx_done_tick(done2)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [7:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr++;
        exp_q.push_back(w);
    endtask

    // Advance one clock; a pop seen in the current cycle retires the FIFO head.
    task automatic step();
        logic p1, p2;
        p1 = fifo_rd;
        p2 = rd2;
        @(posedge clk);
        #1;
        if (p1) rd_ptr++;
        if (p2) empty2 = 1'b1;
    endtask

    task automatic wait_rd(input bit sel, output int gap);
        gap = 0;
        while (((sel ? rd2 : fifo_rd) !== 1'b1) && gap < 3000) begin
            step();
            gap++;
        end
    endtask

    // Caller is in the pop cycle T; observes cycles T+1..T+N against the expected frame.
    task automatic run_frame(input bit sel, input int dv, input int stops,
                             input int chg_k, input int chg_dv, output frame_t r);
        logic [7:0] w;
        logic       e, t;
        int         slot, bits;
        w = 8'h00;
        if (exp_q.size() > 0) w = exp_q.pop_front();
        bits = 9 + int'(PAR);
        r.n = (16 * bits + stops) * (dv + 1);
        r.bad = 0; r.bad_k = 0; r.bad_got = 1'b0; r.bad_want = 1'b0;
        r.done_at = -1; r.done_cnt = 0; r.side_bad = 0;
        for (int k = 1; k <= r.n; k++) begin
            if (k == chg_k) dvsr = 11'(chg_dv);
            step();
            slot = (k - 1) / (16 * (dv + 1));
            if (slot == 0)         e = 1'b0;
            else if (slot <= 8)    e = w[slot-1];
            else if (slot < bits)  e = ^w;
            else                   e = 1'b1;
            t = sel ? tx2 : tx;
            if (t !== e) begin
                if (r.bad == 0) begin
                    r.bad_k = k; r.bad_got = t; r.bad_want = e;
                end
                r.bad++;
            end
            if ((sel ? done2 : tx_done_tick) === 1'b1) begin
                r.done_cnt++;
                if (r.done_at < 0) r.done_at = k;
            end
            if ((sel ? busy2 : tx_busy) !== 1'b1 || (sel ? rd2 : fifo_rd) !== 1'b0)
                r.side_bad++;
        end
    endtask

    task automatic test_reset();
        dvsr = '0;
        Reset = 1'b0;
        push(8'h55);
        step();
        step();
        n_checks += 4;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
        if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else n_pass++;
        if (tx_done_tick !== 1'b0) $display("FAIL reset_done: got %b want 0", tx_done_tick); else n_pass++;
        if (fifo_rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", fifo_rd); else n_pass++;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (fifo_rd !== 1'b1) $display("FAIL release_rd: got %b want 1", fifo_rd); else n_pass++;
    endtask

    task automatic test_single();
        frame_t r;
        run_frame(1'b0, 0, 16, -1, 0, r);
        n_checks += 3;
        if (r.bad != 0) $display("FAIL single_tx: %0d bad clocks, first k=%0d got %b want %b", r.bad, r.bad_k, r.bad_got, r.bad_want); else n_pass++;
        if (r.done_at != 160 + 16 * int'(PAR) || r.done_cnt != 1) $display("FAIL single_done: at %0d x%0d want %0d x1", r.done_at, r.done_cnt, 160 + 16 * int'(PAR)); else n_pass++;
        if (r.side_bad != 0) $display("FAIL single_busy_rd: %0d bad clocks want 0", r.side_bad); else n_pass++;
    endtask

    task automatic test_divisor();
        frame_t r;
        int     gap;
        int     dv;
        dvsr = 11'd3;
        push(8'hA3);
        for (int i = 0; i < 2; i++) begin
            dv = (i == 0) ? 3 : 7;
            if (i == 1) push(8'h3A);
            wait_rd(1'b0, gap);
            n_checks++;
            if (gap != 1) $display("FAIL div%0d_gap: got %0d want 1", i, gap); else n_pass++;
            run_frame(1'b0, dv, 16, (i == 0) ? 100 : -1, 7, r);
            n_checks += 3;
            if (r.bad != 0) $display("FAIL div%0d_tx: %0d bad clocks, first k=%0d got %b want %b", i, r.bad, r.bad_k, r.bad_got, r.bad_want); else n_pass++;
            if (r.done_at != (160 + 16 * int'(PAR)) * (dv + 1) || r.done_cnt != 1) $display("FAIL div%0d_done: at %0d x%0d want %0d x1", i, r.done_at, r.done_cnt, (160 + 16 * int'(PAR)) * (dv + 1)); else n_pass++;
            if (r.side_bad != 0) $display("FAIL div%0d_busy_rd: %0d bad clocks want 0", i, r.side_bad); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        frame_t r;
        int     gap;
        int     bad;
        dvsr = '0;
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        for (int i = 0; i < 3; i++) begin
            wait_rd(1'b0, gap);
            n_checks += 2;
            if (gap != 1) $display("FAIL b2b%0d_gap: got %0d want 1", i, gap); else n_pass++;
            if (tx !== 1'b1) $display("FAIL b2b%0d_idle_tx: got %b want 1", i, tx); else n_pass++;
            run_frame(1'b0, 0, 16, -1, 0, r);
            n_checks += 3;
            if (r.bad != 0) $display("FAIL b2b%0d_tx: %0d bad clocks, first k=%0d got %b want %b", i, r.bad, r.bad_k, r.bad_got, r.bad_want); else n_pass++;
            if (r.done_at != 160 + 16 * int'(PAR) || r.done_cnt != 1) $display("FAIL b2b%0d_done: at %0d x%0d want %0d x1", i, r.done_at, r.done_cnt, 160 + 16 * int'(PAR)); else n_pass++;
            if (r.side_bad != 0) $display("FAIL b2b%0d_busy_rd: %0d bad clocks want 0", i, r.side_bad); else n_pass++;
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (fifo_rd !== 1'b0 || tx_busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL b2b_empty_idle: %0d bad clocks want 0", bad); else n_pass++;
    endtask

    task automatic test_parity();
`ifdef UART_TX_PARITY_EN
        frame_t r;
        int     gap;
        push(8'h07);
        push(8'h03);
        for (int i = 0; i < 2; i++) begin
            wait_rd(1'b0, gap);
            n_checks++;
            if (gap > 2) $display("FAIL par%0d_gap: got %0d want <=2", i, gap); else n_pass++;
            run_frame(1'b0, 0, 16, -1, 0, r);
            n_checks += 2;
            if (r.bad != 0) $display("FAIL par%0d_tx: %0d bad clocks, first k=%0d got %b want %b", i, r.bad, r.bad_k, r.bad_got, r.bad_want); else n_pass++;
            if (r.done_at != 176 || r.done_cnt != 1) $display("FAIL par%0d_done: at %0d x%0d want 176 x1", i, r.done_at, r.done_cnt); else n_pass++;
        end
`endif
    endtask

    task automatic test_two_stop();
        frame_t r;
        int     gap;
        dvsr = '0;
        data2 = 8'h00;
        exp_q.push_back(8'h00);
        empty2 = 1'b0;
        wait_rd(1'b1, gap);
        n_checks++;
        if (rd2 !== 1'b1) $display("FAIL stop2_rd: got %b want 1 after %0d clocks", rd2, gap); else n_pass++;
        run_frame(1'b1, 0, 32, -1, 0, r);
        n_checks += 3;
        if (r.bad != 0) $display("FAIL stop2_tx: %0d bad clocks, first k=%0d got %b want %b", r.bad, r.bad_k, r.bad_got, r.bad_want); else n_pass++;
        if (r.done_at != 176 + 16 * int'(PAR) || r.done_cnt != 1) $display("FAIL stop2_done: at %0d x%0d want %0d x1", r.done_at, r.done_cnt, 176 + 16 * int'(PAR)); else n_pass++;
        if (r.side_bad != 0) $display("FAIL stop2_busy_rd: %0d bad clocks want 0", r.side_bad); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        frame_t     r;
        int         gap;
        logic [7:0] lost;
        dvsr = '0;
        push(8'h5A);
        wait_rd(1'b0, gap);
        n_checks++;
        if (fifo_rd !== 1'b1) $display("FAIL rstmid_rd: got %b want 1 after %0d clocks", fifo_rd, gap); else n_pass++;
        for (int k = 0; k < 72; k++) step();
        push(8'h3C);
        lost = exp_q.pop_front();
        #1;
        Reset = 1'b0;
        #1;
        n_checks += 3;
        if (tx !== 1'b1) $display("FAIL rstmid_tx: got %b want 1 (word %0h dropped)", tx, lost); else n_pass++;
        if (tx_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", tx_busy); else n_pass++;
        if (fifo_rd !== 1'b0) $display("FAIL rstmid_no_rd: got %b want 0", fifo_rd); else n_pass++;
        step();
        step();
        Reset = 1'b1;
        #1;
        n_checks++;
        if (fifo_rd !== 1'b1) $display("FAIL rstmid_release_rd: got %b want 1", fifo_rd); else n_pass++;
        run_frame(1'b0, 0, 16, -1, 0, r);
        n_checks += 3;
        if (r.bad != 0) $display("FAIL rstmid_3c_tx: %0d bad clocks, first k=%0d got %b want %b", r.bad, r.bad_k, r.bad_got, r.bad_want); else n_pass++;
        if (r.done_at != 160 + 16 * int'(PAR) || r.done_cnt != 1) $display("FAIL rstmid_3c_done: at %0d x%0d want %0d x1", r.done_at, r.done_cnt, 160 + 16 * int'(PAR)); else n_pass++;
        if (r.side_bad != 0) $display("FAIL rstmid_3c_busy_rd: %0d bad clocks want 0", r.side_bad); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_single();
        test_divisor();
        test_back_to_back();
        test_parity();
        test_two_stop();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
